prime_search_ctrl: RTL and testbench

PRIME_SEARCH_CTRL -- requirements
Module: prime_search_ctrl

---
 rtl/prime_pkg.sv | 14 +
 rtl/prime_search_ctrl.sv | 136 +++++++++++++
 tb/tb_prime_search_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared width default and FSM state encodings for the prime search controller
package prime_pkg;

    localparam int PRIME_WIDTH = 20;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_TEST   = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

endpackage

// File: rtl/prime_search_ctrl.sv
// rtl/prime_search_ctrl.sv - finds the largest prime below a limit by driving an external trial divider
module prime_search_ctrl
    import prime_pkg::*;
#(
    parameter int WIDTH = PRIME_WIDTH
) (
    input  logic             clk,
    input  logic             RTC_Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] limit,
    input  logic             abort,
    output logic             div_req,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_ack,
    input  logic             div_rem_zero,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] prime,
    output logic [WIDTH-1:0] div_count
);

    localparam logic [WIDTH-1:0] L_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] L_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] L_THREE = WIDTH'(3);
    localparam logic [WIDTH-1:0] L_FOUR  = WIDTH'(4);

    logic [2:0]         r_state;
    logic [WIDTH-1:0]   r_limit;
    logic [WIDTH-1:0]   r_candidate;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   r_prime;
    logic               r_found;
    logic               r_div_req;

    logic [2*WIDTH-1:0] w_div_ext;
    logic [2*WIDTH-1:0] w_square;
    logic               w_sq_over;

    // Full double-width square so divisors near 2^(WIDTH/2) never wrap.
    assign w_div_ext = {{WIDTH{1'b0}}, r_divisor};
    assign w_square  = w_div_ext * w_div_ext;
    assign w_sq_over = w_square > {{WIDTH{1'b0}}, r_candidate};

    always_ff @(posedge clk or negedge RTC_Reset) begin
        if (!RTC_Reset) begin
            r_state     <= S_IDLE;
            r_limit     <= '0;
            r_candidate <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_prime     <= '0;
            r_found     <= 1'b0;
            r_div_req   <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            r_state   <= S_IDLE;
            r_div_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_limit <= limit;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_candidate <= (r_limit < L_TWO) ? '0 : r_limit - L_ONE;
                    r_count     <= '0;
                    r_state     <= S_TEST;
                end
                S_TEST: begin
                    if (r_candidate < L_TWO) begin
                        r_prime <= '0;
                        r_found <= 1'b0;
                        r_state <= S_FINISH;
                    end else if (r_candidate < L_FOUR) begin
                        r_prime <= r_candidate;
                        r_found <= 1'b1;
                        r_state <= S_FINISH;
                    end else if (!r_candidate[0]) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_divisor <= L_THREE;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_sq_over) begin
                        r_prime <= r_candidate;
                        r_found <= 1'b1;
                        r_state <= S_FINISH;
                    end else begin
                        r_div_req <= 1'b1;
                        if (r_count != '1)
                            r_count <= r_count + L_ONE;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (div_ack) begin
                        r_div_req <= 1'b0;
                        if (div_rem_zero) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_divisor <= r_divisor + L_TWO;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_NEXT: begin
                    r_candidate <= r_candidate - L_ONE;
                    r_state     <= S_TEST;
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_div_req <= 1'b0;
                end
            endcase
        end
    end

    assign div_req      = r_div_req;
    assign div_dividend = r_candidate;
    assign div_divisor  = r_divisor;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_FINISH);
    assign found        = r_found;
    assign prime        = r_prime;
    assign div_count    = r_count;

endmodule

// File: tb/tb_prime_search_ctrl.sv
// tb/tb_prime_search_ctrl.sv - directed vector bench for prime_search_ctrl with a latency-programmable divider responder
module tb_prime_search_ctrl;

    localparam int W = 20;

    logic         clk = 1'b0;
    logic         RTC_Reset = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] limit = '0;
    logic         div_ack;
    logic         div_rem_zero;
    logic         div_req;
    logic         busy;
    logic         done;
    logic         found;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic [W-1:0] prime;
    logic [W-1:0] div_count;

    always #5 clk = ~clk;

    prime_search_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .RTC_Reset    (RTC_Reset),
        .start        (start),
        .limit        (limit),
        .abort        (abort),
        .div_req      (div_req),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_ack      (div_ack),
        .div_rem_zero (div_rem_zero),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .prime        (prime),
        .div_count    (div_count)
    );

    int           n_vec = 0;
    int           n_fail = 0;
    int           latency = 1;
    bit           spurious = 1'b0;
    int           wait_cnt = 0;
    bit           ack_sent = 1'b0;
    logic         prev_req = 1'b0;
    logic [W-1:0] held_dd = '0;
    logic [W-1:0] held_dv = '0;
    int           req_cnt = 0;
    int           stab_err = 0;
    logic [2*W-1:0] req_log[$];

    // Behavioural trial divider: acks after `latency` cycles of div_req.
    always @(negedge clk) begin
        div_ack      = 1'b0;
        div_rem_zero = 1'b0;
        if (div_req === 1'b1) begin
            if (!prev_req) begin
                req_cnt++;
                req_log.push_back({div_dividend, div_divisor});
                held_dd = div_dividend;
                held_dv = div_divisor;
            end else if (div_dividend !== held_dd || div_divisor !== held_dv) begin
                stab_err++;
            end
            if (!ack_sent) begin
                if (wait_cnt >= latency - 1) begin
                    div_ack      = 1'b1;
                    div_rem_zero = ((div_dividend % div_divisor) == '0);
                    ack_sent     = 1'b1;
                    wait_cnt     = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end else begin
            ack_sent = 1'b0;
            wait_cnt = 0;
            if (spurious) begin
                div_ack      = 1'b1;
                div_rem_zero = 1'b1;
            end
        end
        prev_req = (div_req === 1'b1);
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_search(input logic [W-1:0] lim, input int lat, input bit spur,
                              output int ndone, output bit timed_out);
        latency  = lat;
        spurious = spur;
        @(negedge clk);
        req_log.delete();
        req_cnt  = 0;
        stab_err = 0;
        start    = 1'b1;
        limit    = lim;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", W'(busy), W'(1));
        ndone     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (done) ndone++;
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (div_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        logic [W-1:0] lim;
        int           lat;
        bit           spur;
        logic         exp_found;
        logic [W-1:0] exp_prime;
        logic [W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int           nd;
        bit           to;
        bit           ok;
        logic [2*W-1:0] exp_log[3];

        #12;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_req", W'(div_req), W'(0));
        check("rst_prime", prime, '0);
        check("rst_count", div_count, '0);
        @(negedge clk);
        RTC_Reset = 1'b1;

        vecs[0]  = '{20'd100,     1, 1'b0, 1'b1, 20'd97,      20'd5};
        vecs[1]  = '{20'd2,       1, 1'b0, 1'b0, 20'd0,       20'd0};
        vecs[2]  = '{20'd26,      1, 1'b0, 1'b1, 20'd23,      20'd3};
        vecs[3]  = '{20'd26,      5, 1'b0, 1'b1, 20'd23,      20'd3};
        vecs[4]  = '{20'd26,      2, 1'b1, 1'b1, 20'd23,      20'd3};
        vecs[5]  = '{20'd0,       1, 1'b0, 1'b0, 20'd0,       20'd0};
        vecs[6]  = '{20'd1,       1, 1'b0, 1'b0, 20'd0,       20'd0};
        vecs[7]  = '{20'd3,       1, 1'b0, 1'b1, 20'd2,       20'd0};
        vecs[8]  = '{20'd5,       1, 1'b0, 1'b1, 20'd3,       20'd0};
        vecs[9]  = '{20'd10,      3, 1'b0, 1'b1, 20'd7,       20'd1};
        vecs[10] = '{20'd1048575, 1, 1'b0, 1'b1, 20'd1048573, 20'd511};

        exp_log[0] = {20'd25, 20'd3};
        exp_log[1] = {20'd25, 20'd5};
        exp_log[2] = {20'd23, 20'd3};

        foreach (vecs[k]) begin
            run_search(vecs[k].lim, vecs[k].lat, vecs[k].spur, nd, to);
            check($sformatf("timeout_l%0d", vecs[k].lim), W'(to), W'(0));
            check($sformatf("done_once_l%0d", vecs[k].lim), W'(nd), W'(1));
            check($sformatf("found_l%0d", vecs[k].lim), W'(found), W'(vecs[k].exp_found));
            check($sformatf("prime_l%0d", vecs[k].lim), prime, vecs[k].exp_prime);
            check($sformatf("div_count_l%0d", vecs[k].lim), div_count, vecs[k].exp_cnt);
            check($sformatf("req_edges_l%0d", vecs[k].lim), W'(req_cnt), vecs[k].exp_cnt);
            check($sformatf("stable_l%0d_lat%0d", vecs[k].lim, vecs[k].lat), W'(stab_err), W'(0));
            if (vecs[k].lim == 20'd26) begin
                check("req_log_len", W'(req_log.size()), W'(3));
                for (int j = 0; j < 3 && j < req_log.size(); j++) begin
                    check($sformatf("req_log_dd%0d", j), req_log[j][2*W-1:W], exp_log[j][2*W-1:W]);
                    check($sformatf("req_log_dv%0d", j), req_log[j][W-1:0], exp_log[j][W-1:0]);
                end
            end
        end
        spurious = 1'b0;

        // Abort during WAIT after a completed search left prime=97.
        run_search(20'd100, 1, 1'b0, nd, to);
        check("pre_abort_prime", prime, 20'd97);
        latency = 4;
        @(negedge clk);
        start = 1'b1;
        limit = 20'd26;
        @(negedge clk);
        start = 1'b0;
        wait_req(ok);
        check("abort_req_seen", W'(ok), W'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        nd = 0;
        check("abort_busy", W'(busy), W'(0));
        check("abort_req", W'(div_req), W'(0));
        check("abort_prime", prime, 20'd97);
        check("abort_found", W'(found), W'(1));
        for (int i = 0; i < 4; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("abort_no_done", W'(nd), W'(0));

        // Abort coinciding with the ack: the result must be discarded.
        latency = 1;
        start = 1'b1;
        limit = 20'd26;
        @(negedge clk);
        start = 1'b0;
        wait_req(ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ack_busy", W'(busy), W'(0));
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("abort_ack_prime", prime, 20'd97);
        check("abort_ack_busy_late", W'(busy), W'(0));

        // Asynchronous reset mid-search.
        latency = 3;
        start = 1'b1;
        limit = 20'd100;
        @(negedge clk);
        start = 1'b0;
        wait_req(ok);
        #2;
        RTC_Reset = 1'b0;
        #1;
        check("arst_req", W'(div_req), W'(0));
        check("arst_busy", W'(busy), W'(0));
        check("arst_done", W'(done), W'(0));
        check("arst_found", W'(found), W'(0));
        check("arst_prime", prime, '0);
        check("arst_count", div_count, '0);
        check("arst_dividend", div_dividend, '0);
        check("arst_divisor", div_divisor, '0);
        @(negedge clk);
        @(negedge clk);
        RTC_Reset = 1'b1;

        run_search(20'd26, 1, 1'b0, nd, to);
        check("post_rst_done", W'(nd), W'(1));
        check("post_rst_prime", prime, 20'd23);
        check("post_rst_count", div_count, 20'd3);
        check("post_rst_reqs", W'(req_cnt), W'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
